uart_phy_cfg: RTL and testbench
===============================

Name: uart_phy_cfg

Overview:
- Parametrised successor to the current UART PHY.
- Runtime-configurable frame format: 5–8 data bits, none/odd/even parity, 1 or 2 stop bits, and a 24-bit clocks-per-bit divisor.
- Takes TX bytes and config words from FIFOs; pushes RX bytes plus per-byte error status to an RX FIFO.
- Adds glitch-rejecting start detection, parity/framing error reporting, RX overrun detection and safe (idle-only) config switching.

Parameters:
- PHY_FIFO_WIDTH, 8, max data bits per frame; must be 8.
- CPB_W, 24, width of clocks-per-bit field.
- CONFIG_DATA_WIDTH, 40, config FIFO word width; bits above CPB_W+4 are ignored.
- DEFAULT_CPB, 868, clocks-per-bit after reset (100 MHz / 115200).

Ports:
- clk  in  1  single system clock.
- rst  in  1  asynchronous, active-high reset.
- tx_serial  out  1  UART TX line; idle high.
- tx_active  out  1  high from start-bit begin to last stop-bit end.
- tx_done  out  1  one-cycle pulse after last stop bit.
- rx_serial  in  1  UART RX line; asynchronous.
- wr_phy_fifo_empty  in  1  TX FIFO empty.
- wr_phy_fifo_en  out  1  TX FIFO read pulse.
- wr_phy_fifo_data  in  PHY_FIFO_WIDTH  TX byte; valid the cycle after en.
- config_fifo_empty  in  1  config FIFO empty.
- config_fifo_en  out  1  config FIFO read pulse.
- config_fifo_data  in  CONFIG_DATA_WIDTH  config word; valid the cycle after en.
- rd_phy_fifo_full  in  1  RX FIFO full.
- rd_phy_fifo_en  out  1  RX FIFO write pulse.
- rd_phy_fifo_data  out  PHY_FIFO_WIDTH+2  {framing_err, parity_err, data}; unused high data bits are 0.
- rx_overrun  out  1  one-cycle pulse when a received byte is dropped because the RX FIFO is full.

Behaviour:
- Reset: tx_serial=1; all other outputs 0; active config = DEFAULT_CPB, 8 data bits, no parity, 1 stop (8N1); TX and RX FSMs IDLE.
- Config word fields:
  - [CPB_W-1:0] = CPB.
  - [CPB_W+1:CPB_W] = data bits (0→5, 1→6, 2→7, 3→8).
  - [CPB_W+3:CPB_W+2] = parity (00 none, 01 odd, 10 even, 11 none).
  - [CPB_W+4] = stop bits (0→1, 1→2).
  - CPB < 4 is clamped to 4.
- Config load:
  - When !config_fifo_empty and no word is pending, pulse config_fifo_en for one cycle.
  - Capture the word into a pending register the next cycle.
  - Pending word becomes active only in a cycle where TX and RX are both IDLE and no RX start edge is detected that cycle.
  - A frame in progress always completes with the old config.
  - A newer word is not read until the pending word is applied.
- TX FSM: IDLE → FETCH → START → DATA → PARITY (skipped if none) → STOP → IDLE.
  - IDLE: if !wr_phy_fifo_empty and no config is pending, pulse wr_phy_fifo_en and go to FETCH.
  - FETCH: latch byte (one cycle).
  - Each bit lasts exactly CPB clocks. Data is sent LSB first, with only the configured number of bits.
  - Parity bit = XOR of sent bits (even), inverted for odd.
  - STOP lasts 1 or 2 bit times.
  - tx_active is high from START through STOP. tx_done pulses in the cycle after STOP ends, with tx_active low.
  - Back-to-back bytes: the next START begins 2 cycles after tx_done (IDLE, FETCH).
- RX path:
  - rx_serial passes through a 2-FF synchroniser; start is detected on a synchronised 1→0 edge.
  - START: sample at count CPB/2 (integer). If the line is high, treat as a glitch and return to IDLE without pushing.
  - Then sample each data / parity / stop bit every CPB clocks from that midpoint.
  - Only the first stop bit is checked; for 2 stop bits the FSM waits the extra bit time before IDLE.
  - parity_err = received parity mismatch. framing_err = first stop sample low.
  - Push: after the first-stop sample, if !rd_phy_fifo_full, pulse rd_phy_fifo_en with the data and flags. Otherwise no push and pulse rx_overrun.
  - After a framing error, RX waits in WAIT_HIGH until the synchronised line is high before accepting a new start (break handling).
- Simultaneous events: TX and RX are fully independent. A config apply never occurs in a cycle where either FSM leaves IDLE.
- Reset mid-frame aborts immediately: tx_serial=1, no push, no pulses, config returns to default, and any pending config word is discarded.

Test Plan:
- Reset, 8N1 default, CPB=868 → TX byte 0x55 → tx_serial low 868 clocks, then bits 1,0,1,0,1,0,1,0, each 868 clocks, then high 868 clocks; tx_done 1 cycle later.
- Config CPB=16, 7 bits, even parity, 2 stop; TX 0x41 → frame 0,1000001,0(parity),1,1, each bit 16 clocks; loop tx→rx gives push {0,0,0x41}.
- Config CPB=16, 8O1; RX frame 0xA5 with wrong parity → rd_phy_fifo_data = {0,1,0xA5}. Same frame with stop low → framing_err=1, and no new start accepted until the line goes high.
- RX 0x3C with rd_phy_fifo_full=1 → no rd_phy_fifo_en; rx_overrun pulses once. A 3-clock low glitch at CPB=16 → no push, RX back to IDLE.
- Config word arrives mid-TX-frame → current frame keeps the old CPB; the next frame uses the new CPB; wr_phy_fifo_en is not asserted while the config is pending.
- Assert rst mid-DATA → tx_serial=1 same cycle; after release, the default 8N1 frame timing is restored.

Source files
------------

// File: rtl/uart_phy_cfg.sv
// UART PHY with a runtime frame format (5-8 data bits, parity, 1/2 stop bits, divisor)
// loaded from a config FIFO. New formats take effect only while both directions are idle.
module uart_phy_cfg #(
    parameter int          PHY_FIFO_WIDTH    = 8,
    parameter int          CPB_W             = 24,
    parameter int          CONFIG_DATA_WIDTH = 40,
    parameter int unsigned DEFAULT_CPB       = 868
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         tx_serial,
    output logic                         tx_active,
    output logic                         tx_done,
    input  logic                         rx_serial,
    input  logic                         wr_phy_fifo_empty,
    output logic                         wr_phy_fifo_en,
    input  logic [PHY_FIFO_WIDTH-1:0]    wr_phy_fifo_data,
    input  logic                         config_fifo_empty,
    output logic                         config_fifo_en,
    input  logic [CONFIG_DATA_WIDTH-1:0] config_fifo_data,
    input  logic                         rd_phy_fifo_full,
    output logic                         rd_phy_fifo_en,
    output logic [PHY_FIFO_WIDTH+1:0]    rd_phy_fifo_data,
    output logic                         rx_overrun
);
    localparam int CFG_USED = CPB_W + 5;

    typedef enum logic [2:0] {TX_IDLE, TX_FETCH, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_STOP2,
                              RX_WAIT_HIGH} rx_state_t;

    tx_state_t tx_state;
    rx_state_t rx_state;

    logic [CPB_W-1:0]    cfg_cpb;
    logic [1:0]          cfg_bits;
    logic                cfg_par_en, cfg_par_odd, cfg_stop2;
    logic                cfg_fetch, cfg_pending, cfg_apply;
    logic [CFG_USED-1:0] cfg_word;
    logic [CPB_W-1:0]    new_cpb;
    logic [2:0]          last_bit;
    logic                unused_cfg_bits;

    logic                      rx_s1, rx_s2, rx_prev, rx_start_edge;
    logic [CPB_W-1:0]          rx_cnt;
    logic [2:0]                rx_bit;
    logic [PHY_FIFO_WIDTH-1:0] rx_data;
    logic                      rx_par, rx_perr, rx_bit_end;

    logic [CPB_W-1:0]          tx_cnt;
    logic [2:0]                tx_bit;
    logic [PHY_FIFO_WIDTH-1:0] tx_shift;
    logic                      tx_par, tx_stop_n, tx_bit_end;

    assign unused_cfg_bits = ^config_fifo_data[CONFIG_DATA_WIDTH-1:CFG_USED];
    assign new_cpb    = (cfg_word[CPB_W-1:0] < CPB_W'(4)) ? CPB_W'(4) : cfg_word[CPB_W-1:0];
    assign last_bit   = 3'd4 + {1'b0, cfg_bits};
    assign tx_bit_end = (tx_cnt == cfg_cpb - CPB_W'(1));
    assign rx_bit_end = (rx_cnt == cfg_cpb - CPB_W'(1));
    assign rx_start_edge = (rx_state == RX_IDLE) && rx_prev && !rx_s2;
    assign cfg_apply  = cfg_pending && (tx_state == TX_IDLE) && (rx_state == RX_IDLE) && !rx_start_edge;
    // A fetched-but-not-applied word holds off new TX bytes so the config can find an idle gap.
    assign wr_phy_fifo_en = !rst && (tx_state == TX_IDLE) && !wr_phy_fifo_empty
                            && !cfg_fetch && !cfg_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            config_fifo_en <= 1'b0;
            cfg_fetch      <= 1'b0;
            cfg_pending    <= 1'b0;
            cfg_word       <= '0;
            cfg_cpb        <= CPB_W'(DEFAULT_CPB);
            cfg_bits       <= 2'd3;
            cfg_par_en     <= 1'b0;
            cfg_par_odd    <= 1'b0;
            cfg_stop2      <= 1'b0;
        end else begin
            config_fifo_en <= !config_fifo_empty && !cfg_pending && !cfg_fetch && !config_fifo_en;
            cfg_fetch      <= config_fifo_en;
            if (cfg_fetch) begin
                cfg_word    <= config_fifo_data[CFG_USED-1:0];
                cfg_pending <= 1'b1;
            end else if (cfg_apply) begin
                cfg_pending <= 1'b0;
                cfg_cpb     <= new_cpb;
                cfg_bits    <= cfg_word[CPB_W+1:CPB_W];
                cfg_par_en  <= cfg_word[CPB_W+3] ^ cfg_word[CPB_W+2];
                cfg_par_odd <= (cfg_word[CPB_W+3:CPB_W+2] == 2'b01);
                cfg_stop2   <= cfg_word[CPB_W+4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state  <= TX_IDLE;
            tx_serial <= 1'b1;
            tx_active <= 1'b0;
            tx_done   <= 1'b0;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_shift  <= '0;
            tx_par    <= 1'b0;
            tx_stop_n <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (tx_state)
                TX_IDLE: if (wr_phy_fifo_en) tx_state <= TX_FETCH;
                TX_FETCH: begin
                    tx_shift  <= wr_phy_fifo_data;
                    tx_par    <= 1'b0;
                    tx_cnt    <= '0;
                    tx_serial <= 1'b0;
                    tx_active <= 1'b1;
                    tx_state  <= TX_START;
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt    <= '0;
                        tx_bit    <= '0;
                        tx_serial <= tx_shift[0];
                        tx_state  <= TX_DATA;
                    end else tx_cnt <= tx_cnt + CPB_W'(1);
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt   <= '0;
                        tx_par   <= tx_par ^ tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        if (tx_bit == last_bit) begin
                            if (cfg_par_en) begin
                                tx_serial <= tx_par ^ tx_shift[0] ^ cfg_par_odd;
                                tx_state  <= TX_PARITY;
                            end else begin
                                tx_serial <= 1'b1;
                                tx_stop_n <= 1'b0;
                                tx_state  <= TX_STOP;
                            end
                        end else begin
                            tx_bit    <= tx_bit + 3'd1;
                            tx_serial <= tx_shift[1];
                        end
                    end else tx_cnt <= tx_cnt + CPB_W'(1);
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_cnt    <= '0;
                        tx_serial <= 1'b1;
                        tx_stop_n <= 1'b0;
                        tx_state  <= TX_STOP;
                    end else tx_cnt <= tx_cnt + CPB_W'(1);
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_stop_n == cfg_stop2) begin
                            tx_active <= 1'b0;
                            tx_done   <= 1'b1;
                            tx_state  <= TX_IDLE;
                        end else tx_stop_n <= 1'b1;
                    end else tx_cnt <= tx_cnt + CPB_W'(1);
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1            <= 1'b1;
            rx_s2            <= 1'b1;
            rx_prev          <= 1'b1;
            rx_state         <= RX_IDLE;
            rx_cnt           <= '0;
            rx_bit           <= '0;
            rx_data          <= '0;
            rx_par           <= 1'b0;
            rx_perr          <= 1'b0;
            rd_phy_fifo_en   <= 1'b0;
            rd_phy_fifo_data <= '0;
            rx_overrun       <= 1'b0;
        end else begin
            rx_s1          <= rx_serial;
            rx_s2          <= rx_s1;
            rx_prev        <= rx_s2;
            rd_phy_fifo_en <= 1'b0;
            rx_overrun     <= 1'b0;
            case (rx_state)
                RX_IDLE: if (rx_start_edge) begin
                    rx_cnt   <= '0;
                    rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == (cfg_cpb >> 1)) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_data  <= '0;
                        rx_par   <= 1'b0;
                        rx_perr  <= 1'b0;
                        rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
                    end else rx_cnt <= rx_cnt + CPB_W'(1);
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt          <= '0;
                        rx_data[rx_bit] <= rx_s2;
                        rx_par          <= rx_par ^ rx_s2;
                        if (rx_bit == last_bit) rx_state <= cfg_par_en ? RX_PARITY : RX_STOP;
                        else rx_bit <= rx_bit + 3'd1;
                    end else rx_cnt <= rx_cnt + CPB_W'(1);
                end
                RX_PARITY: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_perr  <= rx_par ^ rx_s2 ^ cfg_par_odd;
                        rx_state <= RX_STOP;
                    end else rx_cnt <= rx_cnt + CPB_W'(1);
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        if (rd_phy_fifo_full) rx_overrun <= 1'b1;
                        else begin
                            rd_phy_fifo_en   <= 1'b1;
                            rd_phy_fifo_data <= {~rx_s2, rx_perr, rx_data};
                        end
                        // A low stop bit may be a break: wait for the line to recover first.
                        if (!rx_s2) rx_state <= RX_WAIT_HIGH;
                        else rx_state <= cfg_stop2 ? RX_STOP2 : RX_IDLE;
                    end else rx_cnt <= rx_cnt + CPB_W'(1);
                end
                RX_STOP2: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                    end else rx_cnt <= rx_cnt + CPB_W'(1);
                end
                RX_WAIT_HIGH: if (rx_s2) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_phy_cfg.sv
// Directed bench for uart_phy_cfg: TX frame timing, loopback RX, error flags,
// overrun, glitch rejection, idle-only config switching and mid-frame reset.
module tb_uart_phy_cfg;
    logic        clk = 1'b0;
    logic        rst;
    logic        tx_serial, tx_active, tx_done, rx_serial;
    logic        wr_phy_fifo_empty, wr_phy_fifo_en;
    logic [7:0]  wr_phy_fifo_data = '0;
    logic        config_fifo_empty, config_fifo_en;
    logic [39:0] config_fifo_data = '0;
    logic        rd_phy_fifo_full, rd_phy_fifo_en, rx_overrun;
    logic [9:0]  rd_phy_fifo_data;
    logic        loop_en, rx_drv;

    int checks = 0;
    int errors = 0;

    logic [7:0]  tx_mem [0:15];
    logic [39:0] cfg_mem [0:7];
    logic [9:0]  rx_log [0:31];
    int tx_wr = 0, tx_rd = 0, cfg_wr = 0, cfg_rd = 0;
    int rx_n = 0, ovr_n = 0, txen_n = 0, cyc = 0;
    int ts, td, ts2, td2, en_before;

    always #5 clk = ~clk;

    assign rx_serial         = loop_en ? tx_serial : rx_drv;
    assign wr_phy_fifo_empty = (tx_wr == tx_rd);
    assign config_fifo_empty = (cfg_wr == cfg_rd);

    uart_phy_cfg dut (
        .clk(clk), .rst(rst),
        .tx_serial(tx_serial), .tx_active(tx_active), .tx_done(tx_done),
        .rx_serial(rx_serial),
        .wr_phy_fifo_empty(wr_phy_fifo_empty), .wr_phy_fifo_en(wr_phy_fifo_en),
        .wr_phy_fifo_data(wr_phy_fifo_data),
        .config_fifo_empty(config_fifo_empty), .config_fifo_en(config_fifo_en),
        .config_fifo_data(config_fifo_data),
        .rd_phy_fifo_full(rd_phy_fifo_full), .rd_phy_fifo_en(rd_phy_fifo_en),
        .rd_phy_fifo_data(rd_phy_fifo_data), .rx_overrun(rx_overrun)
    );

    // FIFO models: read data appears the cycle after the enable pulse.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_phy_fifo_en) begin
            wr_phy_fifo_data <= tx_mem[tx_rd];
            tx_rd  <= tx_rd + 1;
            txen_n <= txen_n + 1;
        end
        if (config_fifo_en) begin
            config_fifo_data <= cfg_mem[cfg_rd];
            cfg_rd <= cfg_rd + 1;
        end
        if (rd_phy_fifo_en) begin
            rx_log[rx_n] <= rd_phy_fifo_data;
            rx_n <= rx_n + 1;
        end
        if (rx_overrun) ovr_n <= ovr_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_tx(input logic [7:0] b);
        tx_mem[tx_wr] = b;
        tx_wr++;
    endtask

    task automatic push_cfg(input int cpb, input logic [1:0] bits, input logic [1:0] par,
                            input logic stop2);
        cfg_mem[cfg_wr] = {11'd0, stop2, par, bits, cpb[23:0]};
        cfg_wr++;
    endtask

    task automatic drive_bit(input logic v, input int cpb);
        rx_drv = v;
        repeat (cpb) @(negedge clk);
    endtask

    // 8-bit frame at 16 clocks/bit with a parity bit and a chosen stop level.
    task automatic rx_send(input logic [7:0] d, input logic pbit, input logic stop_lvl);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
        drive_bit(pbit, 16);
        drive_bit(stop_lvl, 16);
    endtask

    task automatic wait_active(input string tag);
        logic seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_active === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    // exp_bits[k] is the k-th bit on the line (start first); every cycle of every bit is compared.
    task automatic check_frame(input string tag, input logic [15:0] exp_bits, input int nb,
                               input int cpb, input logic started,
                               output int t_start, output int t_done);
        logic found = started;
        int good;
        if (!started) begin
            for (int k = 0; k < 20000; k++) begin
                @(negedge clk);
                if (tx_serial === 1'b0) begin
                    found = 1'b1;
                    break;
                end
            end
        end
        check({tag, "_start"}, {31'd0, found}, 32'd1);
        t_start = cyc;
        for (int b = 0; b < nb; b++) begin
            good = 0;
            for (int c = 0; c < cpb; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (tx_serial === exp_bits[b] && tx_active === 1'b1) good++;
            end
            check($sformatf("%s_bit%0d", tag, b), good, cpb);
        end
        @(negedge clk);
        t_done = cyc;
        check({tag, "_done"}, {29'd0, tx_done, tx_active, tx_serial}, 32'b101);
        @(negedge clk);
        check({tag, "_done_once"}, {31'd0, tx_done}, 32'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        loop_en = 1'b0;
        rx_drv = 1'b1;
        rd_phy_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_serial", {31'd0, tx_serial}, 32'd1);
        check("rst_pulses", {26'd0, tx_active, tx_done, wr_phy_fifo_en, config_fifo_en,
                             rd_phy_fifo_en, rx_overrun}, 32'd0);
        check("rst_rd_data", {22'd0, rd_phy_fifo_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_tx_serial", {31'd0, tx_serial}, 32'd1);

        // Default 8N1 at 868 clocks/bit.
        push_tx(8'h55);
        check_frame("t1_55", 16'h02AA, 10, 868, 1'b0, ts, td);

        // 7E2 at 16 clocks/bit, looped back into RX.
        push_cfg(16, 2'd2, 2'b10, 1'b1);
        repeat (10) @(negedge clk);
        loop_en = 1'b1;
        push_tx(8'h41);
        check_frame("t2_41", 16'h0682, 11, 16, 1'b0, ts, td);
        repeat (20) @(negedge clk);
        loop_en = 1'b0;
        check("t2_rx_count", rx_n, 1);
        check("t2_rx_data", {22'd0, rx_log[0]}, 32'h041);

        // 8O1 at 16: parity error, then framing error held low as a break.
        push_cfg(16, 2'd3, 2'b01, 1'b0);
        repeat (40) @(negedge clk);
        rx_send(8'hA5, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("t3_perr_count", rx_n, 2);
        check("t3_perr_data", {22'd0, rx_log[1]}, 32'h1A5);
        rx_send(8'hA5, 1'b1, 1'b0);
        repeat (64) @(negedge clk);
        check("t3_ferr_count", rx_n, 3);
        check("t3_ferr_data", {22'd0, rx_log[2]}, 32'h2A5);
        rx_drv = 1'b1;
        repeat (8) @(negedge clk);
        rx_send(8'h5A, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t3_recover_data", {22'd0, rx_log[3]}, 32'h05A);

        // Overrun with full RX FIFO, then a short glitch.
        rd_phy_fifo_full = 1'b1;
        rx_send(8'h3C, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        rd_phy_fifo_full = 1'b0;
        check("t4_no_push", rx_n, 4);
        check("t4_overrun", ovr_n, 1);
        rx_drv = 1'b0;
        repeat (3) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_glitch_no_push", rx_n, 4);
        check("t4_glitch_no_ovr", ovr_n, 1);
        rx_send(8'hC3, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("t4_after_glitch", {22'd0, rx_log[4]}, 32'h0C3);

        // Config arrives mid-frame: frame 1 keeps 8O1/16, frame 2 uses 8N1/8.
        en_before = txen_n;
        push_tx(8'h0F);
        push_tx(8'hF0);
        wait_active("t5_active");
        push_cfg(8, 2'd3, 2'b00, 1'b0);
        check_frame("t5_0f", 16'h061E, 11, 16, 1'b1, ts, td);
        check("t5_no_read_pending", txen_n, en_before + 1);
        check_frame("t5_f0", 16'h03E0, 10, 8, 1'b0, ts, td);

        // Back-to-back bytes at 8N1/8.
        push_tx(8'h81);
        push_tx(8'h18);
        check_frame("t6_81", 16'h0302, 10, 8, 1'b0, ts, td);
        check_frame("t6_18", 16'h0230, 10, 8, 1'b0, ts2, td2);
        check("t6_gap", ts2 - td, 2);

        // Reset during DATA with a config word pending.
        push_tx(8'h00);
        wait_active("t7_active");
        push_cfg(20, 2'd3, 2'b00, 1'b0);
        repeat (12) @(negedge clk);
        check("t7_in_data", {31'd0, tx_serial}, 32'd0);
        rst = 1'b1;
        #1;
        check("t7_rst_serial", {30'd0, tx_active, tx_serial}, 32'b01);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_tx(8'h55);
        check_frame("t7_55", 16'h02AA, 10, 868, 1'b0, ts, td);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
